// File: rtl/kyber_pkg.sv
// Shared Kyber constants and coefficient type used by the polynomial datapath.
package kyber_pkg;

    localparam int KYBER_Q          = 3329;
    localparam int KYBER_N          = 256;
    localparam int KYBER_POLY_WIDTH = 16;

    typedef logic [KYBER_POLY_WIDTH-1:0] coeff_t;

    // Number of stream beats needed to carry one polynomial.
    function automatic int beats_per_poly(input int n, input int lanes);
        return n / lanes;
    endfunction

endpackage

// File: rtl/sub_mod_q.sv
// Single-lane combinational (a - b) mod Q with an out-of-range indicator.
// Only the low 12 bits of each container take part in the arithmetic; the
// range check looks at the full container width.
module sub_mod_q #(
    parameter int W = 16,
    parameter int Q = 3329
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r,
    output logic         range_err
);

    logic [12:0] diff;
    logic [12:0] diff_fix;

    // Difference in 13 bits; bit 12 is the sign, so a single +Q folds
    // negative in-range results back into [0, Q).
    always_comb begin
        diff      = {1'b0, a[11:0]} - {1'b0, b[11:0]};
        diff_fix  = diff[12] ? (diff + 13'(Q)) : diff;
        r         = {{(W-13){1'b0}}, diff_fix};
        range_err = (a >= W'(Q)) || (b >= W'(Q));
    end

endmodule

// File: rtl/poly_sub_stream.sv
// Streaming Kyber polynomial subtractor: LANES coefficient pairs per beat,
// one output register stage, beat counter with end-of-polynomial marker and
// a sticky range-error flag for non-canonical inputs.
module poly_sub_stream
    import kyber_pkg::*;
#(
    parameter int POLY_WIDTH = KYBER_POLY_WIDTH,
    parameter int N          = KYBER_N,
    parameter int Q          = KYBER_Q,
    parameter int LANES      = 4,
    localparam int BEATS     = beats_per_poly(N, LANES),
    localparam int IDX_W     = $clog2(BEATS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [POLY_WIDTH*LANES-1:0] a_lanes,
    input  logic [POLY_WIDTH*LANES-1:0] b_lanes,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [POLY_WIDTH*LANES-1:0] r_lanes,
    output logic                        out_last,
    output logic [IDX_W-1:0]            beat_idx,
    output logic                        range_err,
    input  logic                        clr_err
);

    logic [POLY_WIDTH*LANES-1:0] r_next;
    logic [LANES-1:0]            lane_err;
    logic [IDX_W-1:0]            cnt_reg;
    logic                        accept;

    // The output register can take a new beat whenever it is empty or
    // being drained this cycle; no path from in_valid to out_valid.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_last = (beat_idx == IDX_W'(BEATS - 1));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            sub_mod_q #(
                .W (POLY_WIDTH),
                .Q (Q)
            ) u_sub (
                .a         (a_lanes[POLY_WIDTH*gi +: POLY_WIDTH]),
                .b         (b_lanes[POLY_WIDTH*gi +: POLY_WIDTH]),
                .r         (r_next[POLY_WIDTH*gi +: POLY_WIDTH]),
                .range_err (lane_err[gi])
            );
        end
    endgenerate

    // Output register and beat counter: load on accept, drop valid on a
    // transfer with nothing new behind it, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            r_lanes   <= '0;
            beat_idx  <= '0;
            cnt_reg   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            r_lanes   <= r_next;
            beat_idx  <= cnt_reg;
            cnt_reg   <= (cnt_reg == IDX_W'(BEATS - 1)) ? '0 : cnt_reg + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky range error; a fresh error beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            range_err <= 1'b0;
        end else if (accept && (|lane_err)) begin
            range_err <= 1'b1;
        end else if (clr_err) begin
            range_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_poly_sub_stream.sv
// Self-checking bench for poly_sub_stream: lane-vector table, full-polynomial
// streaming, backpressure, range error, mid-polynomial reset and random stalls,
// all cross-checked by a queue scoreboard against a software model.
module tb_poly_sub_stream;

    localparam int W     = 16;
    localparam int N     = 256;
    localparam int Q     = 3329;
    localparam int LANES = 4;
    localparam int BEATS = N / LANES;
    localparam int IDX_W = $clog2(BEATS);

    typedef logic [LANES-1:0][W-1:0] lanes_t;

    typedef struct {
        lanes_t a;
        lanes_t b;
        lanes_t r;
    } vec_t;

    typedef struct {
        lanes_t r;
        int     idx;
        bit     last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    lanes_t           a_lanes;
    lanes_t           b_lanes;
    logic             out_valid;
    logic             out_ready;
    lanes_t           r_lanes;
    logic             out_last;
    logic [IDX_W-1:0] beat_idx;
    logic             range_err;
    logic             clr_err;

    int   vec_count  = 0;
    int   miscompares = 0;
    int   xfer_cnt   = 0;
    int   last_cnt   = 0;
    int   exp_cnt    = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    poly_sub_stream #(
        .POLY_WIDTH (W),
        .N          (N),
        .Q          (Q),
        .LANES      (LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_lanes   (a_lanes),
        .b_lanes   (b_lanes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_lanes   (r_lanes),
        .out_last  (out_last),
        .beat_idx  (beat_idx),
        .range_err (range_err),
        .clr_err   (clr_err)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: each lane (a mod 4096) - (b mod 4096), +Q if negative, 13-bit result.
    function automatic lanes_t model_sub(input lanes_t a, input lanes_t b);
        lanes_t m;
        for (int k = 0; k < LANES; k++) begin
            int d;
            d = int'(a[k][11:0]) - int'(b[k][11:0]);
            if (d < 0) d = d + Q;
            m[k] = W'(d & 8191);
        end
        return m;
    endfunction

    function automatic lanes_t rand_lanes();
        lanes_t v;
        for (int k = 0; k < LANES; k++) v[k] = W'($urandom_range(0, Q - 1));
        return v;
    endfunction

    // Scoreboard: observe transfers and accepts between clock edges.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            exp_cnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    vec_count++;
                    miscompares++;
                    $display("FAIL sb_underflow @%0t: got beat %0d expected none", $time, beat_idx);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_r_lanes", r_lanes, e.r);
                    check("sb_beat_idx", beat_idx, e.idx);
                    check("sb_out_last", out_last, e.last);
                end
                xfer_cnt++;
                if (out_last) last_cnt++;
                $display("xfer beat=%0d last=%0d r=%h", beat_idx, out_last, r_lanes);
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e.r    = model_sub(a_lanes, b_lanes);
                e.idx  = exp_cnt;
                e.last = (exp_cnt == BEATS - 1);
                sb_q.push_back(e);
                exp_cnt = (exp_cnt + 1) % BEATS;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // All drive tasks start and end just after a rising edge.
    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; clr_err = 1'b0; out_ready = 1'b1;
        a_lanes = '0; b_lanes = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_beat(input lanes_t a, input lanes_t b);
        int t = 0;
        a_lanes = a; b_lanes = b; in_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        check("send_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic stream(input int n);
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            a_lanes = rand_lanes();
            b_lanes = rand_lanes();
            @(negedge clk);
            check("stream_in_ready", in_ready, 1'b1);
            if (i > 0) check("stream_no_bubble", out_valid, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    vec_t   vecs[4];
    lanes_t x1, x2, bad;
    int     sent;
    bit     acc;
    int     guard;

    initial begin
        vecs[0].a = {16'd3328, 16'd0,    16'd3,    16'd5};
        vecs[0].b = {16'd0,    16'd3328, 16'd5,    16'd3};
        vecs[0].r = {16'd3328, 16'd1,    16'd3327, 16'd2};
        vecs[1].a = {16'd3328, 16'd1664, 16'd0,    16'd100};
        vecs[1].b = {16'd3328, 16'd1665, 16'd1,    16'd100};
        vecs[1].r = {16'd0,    16'd3328, 16'd3328, 16'd0};
        vecs[2].a = {16'd3,    16'd2,    16'd1,    16'd0};
        vecs[2].b = {16'd3328, 16'd3328, 16'd3328, 16'd3328};
        vecs[2].r = {16'd4,    16'd3,    16'd2,    16'd1};
        vecs[3].a = {16'd3328, 16'd1,    16'd2000, 16'd3000};
        vecs[3].b = {16'd1,    16'd3000, 16'd2000, 16'd1};
        vecs[3].r = {16'd3327, 16'd330,  16'd0,    16'd2999};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_r_lanes", r_lanes, '0);
        check("rst_beat_idx", beat_idx, '0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_range_err", range_err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Lane table: one-cycle latency, hand-computed results
        for (int i = 0; i < 4; i++) begin
            send_beat(vecs[i].a, vecs[i].b);
            @(negedge clk);
            check("tbl_out_valid", out_valid, 1'b1);
            check("tbl_r_lanes", r_lanes, vecs[i].r);
            check("tbl_beat_idx", beat_idx, i);
            check("tbl_out_last", out_last, 1'b0);
            $display("vec %0d a=%h b=%h r=%h", i, vecs[i].a, vecs[i].b, r_lanes);
            @(posedge clk); #1;
        end

        // Full polynomial plus one wrap beat
        do_reset();
        xfer_cnt = 0; last_cnt = 0;
        stream(BEATS + 1);
        @(negedge clk);
        @(posedge clk); #1;
        check("poly_xfers", xfer_cnt, BEATS + 1);
        check("poly_lasts", last_cnt, 1);
        @(negedge clk);
        check("idle_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;

        // Backpressure: 5 stalled cycles with a pending beat
        do_reset();
        xfer_cnt = 0;
        x1 = rand_lanes(); x2 = rand_lanes();
        out_ready = 1'b0;
        a_lanes = x1; b_lanes = rand_lanes(); in_valid = 1'b1;
        x1 = model_sub(x1, b_lanes);
        @(negedge clk);
        check("bp_first_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        a_lanes = x2; b_lanes = rand_lanes();
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_r_hold", r_lanes, x1);
            check("bp_idx_hold", beat_idx, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        check("bp_xfers", xfer_cnt, 2);
        check("bp_sb_empty", sb_q.size(), 0);

        // Range error: sticky, clear, clear vs new error
        do_reset();
        bad = rand_lanes();
        bad[2] = 16'd3329;
        send_beat(bad, rand_lanes());
        @(negedge clk);
        check("rerr_set", range_err, 1'b1);
        repeat (3) @(negedge clk);
        check("rerr_sticky", range_err, 1'b1);
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        @(negedge clk);
        check("rerr_cleared", range_err, 1'b0);
        @(posedge clk); #1;
        bad = rand_lanes();
        bad[1] = 16'd4095;
        clr_err = 1'b1;
        send_beat(rand_lanes(), bad);
        clr_err = 1'b0;
        @(negedge clk);
        check("rerr_new_wins", range_err, 1'b1);
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        send_beat(rand_lanes(), rand_lanes());
        @(negedge clk);
        check("rerr_good_beat", range_err, 1'b0);
        @(posedge clk); #1;

        // Reset after beat 20 is accepted
        do_reset();
        stream(21);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_idx", beat_idx, 0);
        @(posedge clk); #1;
        xfer_cnt = 0; last_cnt = 0;
        stream(BEATS);
        @(negedge clk);
        @(posedge clk); #1;
        check("mid_xfers", xfer_cnt, BEATS);
        check("mid_lasts", last_cnt, 1);

        // Random stalls over 10 polynomials
        do_reset();
        xfer_cnt = 0; last_cnt = 0; sent = 0; guard = 0;
        while (sent < 10 * BEATS && guard < 20000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) sent++;
            if (acc || !in_valid) begin
                if (sent < 10 * BEATS && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    a_lanes = rand_lanes();
                    b_lanes = rand_lanes();
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        @(negedge clk);
        @(posedge clk); #1;
        check("rand_sent", sent, 10 * BEATS);
        check("rand_xfers", xfer_cnt, 10 * BEATS);
        check("rand_lasts", last_cnt, 10);
        check("rand_sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
